// File: rtl/uart_mapped_io.sv
// rtl/uart_mapped_io.sv - memory-mapped UART adapter with TX/RX byte FIFOs and level irq
module uart_mio_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [7:0]             push_data,
    input  logic                   pop,
    output logic [7:0]             head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   push_ok
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          pop_ok;

    assign pop_ok  = pop && (count != '0);
    // Room is judged after a same-cycle pop, so a full FIFO still takes a push.
    assign push_ok = push && ((count - CW'(pop_ok)) < CW'(DEPTH));
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end
endmodule

module uart_mapped_io #(
    parameter logic [15:0] BASE_ADDR  = 16'hF000,
    parameter int          FIFO_DEPTH = 4,
    parameter int          TX_HOLD    = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [7:0]  din,
    input  logic        read_en,
    input  logic        write_en,
    input  logic        acc_en,
    output logic [7:0]  dout,
    output logic        hit,
    output logic [7:0]  txdata,
    output logic        txclk,
    input  logic        txready,
    input  logic [7:0]  rxdata,
    output logic        rxclk,
    input  logic        rxready,
    output logic        irq
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int HW = (TX_HOLD > 1) ? $clog2(TX_HOLD) : 1;

    typedef enum logic [1:0] {TX_IDLE, TX_STROBE, TX_HOLDOFF} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_ACK, RX_WAIT} rx_state_t;

    tx_state_t     tx_state;
    rx_state_t     rx_state;
    logic [HW-1:0] hold_cnt;

    logic [15:0]   offset;
    logic          is_wr;
    logic          acc;
    logic          rx_pop;
    logic          tx_push;
    logic          ctrl_wr;
    logic          tx_pop;
    logic          rx_push;
    logic [7:0]    tx_head;
    logic [7:0]    rx_head;
    logic [CW-1:0] tx_count;
    logic [CW-1:0] rx_count;
    logic          tx_push_ok;
    logic          rx_push_ok;
    logic          rx_ie;
    logic          tx_ie;
    logic          rx_ovr;
    logic          tx_ovf;
    logic          tx_full;
    logic          tx_empty;
    logic          rx_avail;
    logic          rx_full;
    logic [7:0]    status;
    logic          unused_bits;

    assign offset  = addr - BASE_ADDR;
    assign hit     = offset < 16'd3;
    // A cycle with both read_en and write_en behaves as a read.
    assign is_wr   = write_en & ~read_en;
    assign acc     = acc_en & hit;
    assign rx_pop  = acc & read_en & (offset == 16'd0);
    assign tx_push = acc & is_wr & (offset == 16'd0);
    assign ctrl_wr = acc & is_wr & (offset == 16'd2);
    assign tx_pop  = (tx_state == TX_IDLE) & (tx_count != '0) & txready;
    assign rx_push = (rx_state == RX_IDLE) & rxready;

    assign tx_full  = tx_count == CW'(FIFO_DEPTH);
    assign tx_empty = tx_count == '0;
    assign rx_avail = rx_count != '0;
    assign rx_full  = rx_count == CW'(FIFO_DEPTH);
    assign status   = {2'b00, tx_ovf, rx_ovr, rx_full, rx_avail, tx_empty, tx_full};

    assign unused_bits = ^din[6:2];

    uart_mio_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tx_push),
        .push_data (din),
        .pop       (tx_pop),
        .head      (tx_head),
        .count     (tx_count),
        .push_ok   (tx_push_ok)
    );

    uart_mio_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rx_push),
        .push_data (rxdata),
        .pop       (rx_pop),
        .head      (rx_head),
        .count     (rx_count),
        .push_ok   (rx_push_ok)
    );

    always_comb begin
        dout = 8'h00;
        if (hit && read_en) begin
            case (offset[1:0])
                2'd0:    dout = rx_avail ? rx_head : 8'h00;
                2'd1:    dout = status;
                2'd2:    dout = {6'b000000, tx_ie, rx_ie};
                default: dout = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ie  <= 1'b0;
            tx_ie  <= 1'b0;
            rx_ovr <= 1'b0;
            tx_ovf <= 1'b0;
            irq    <= 1'b0;
        end else begin
            if (ctrl_wr) begin
                rx_ie <= din[0];
                tx_ie <= din[1];
                if (din[7]) begin
                    rx_ovr <= 1'b0;
                    tx_ovf <= 1'b0;
                end
            end
            // An overflow landing on the same cycle as a clear is kept.
            if (tx_push && !tx_push_ok) begin
                tx_ovf <= 1'b1;
            end
            if (rx_push && !rx_push_ok) begin
                rx_ovr <= 1'b1;
            end
            irq <= (rx_ie & rx_avail) | (tx_ie & tx_empty);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            txdata   <= 8'h00;
            txclk    <= 1'b0;
            hold_cnt <= '0;
        end else begin
            case (tx_state)
                TX_IDLE: begin
                    if (tx_pop) begin
                        txdata   <= tx_head;
                        txclk    <= 1'b1;
                        tx_state <= TX_STROBE;
                    end
                end
                TX_STROBE: begin
                    txclk    <= 1'b0;
                    hold_cnt <= '0;
                    tx_state <= TX_HOLDOFF;
                end
                TX_HOLDOFF: begin
                    if (hold_cnt == HW'(TX_HOLD - 1)) begin
                        tx_state <= TX_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt + HW'(1);
                    end
                end
                default: begin
                    txclk    <= 1'b0;
                    tx_state <= TX_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= RX_IDLE;
            rxclk    <= 1'b0;
        end else begin
            case (rx_state)
                RX_IDLE: begin
                    if (rxready) begin
                        rxclk    <= 1'b1;
                        rx_state <= RX_ACK;
                    end
                end
                RX_ACK: begin
                    rxclk    <= 1'b0;
                    rx_state <= RX_WAIT;
                end
                RX_WAIT: begin
                    if (!rxready) begin
                        rx_state <= RX_IDLE;
                    end
                end
                default: begin
                    rxclk    <= 1'b0;
                    rx_state <= RX_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_mapped_io.sv
// tb/tb_uart_mapped_io.sv - self-checking bench for uart_mapped_io
module tb_uart_mapped_io;
    localparam logic [15:0] A_DATA = 16'hF000;
    localparam logic [15:0] A_STAT = 16'hF001;
    localparam logic [15:0] A_CTRL = 16'hF002;
    localparam logic [15:0] BASE   = 16'hF000;
    localparam int          DEPTH  = 4;
    localparam int          HOLD   = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] addr;
    logic [7:0]  din;
    logic        read_en;
    logic        write_en;
    logic        acc_en;
    logic [7:0]  dout;
    logic        hit;
    logic [7:0]  txdata;
    logic        txclk;
    logic        txready;
    logic [7:0]  rxdata;
    logic        rxclk;
    logic        rxready;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_on = 1'b0;

    logic [7:0] rxq[$];
    logic [7:0] txq[$];
    bit         m_rx_ie, m_tx_ie, m_rx_ovr, m_tx_ovf;
    bit         m_txclk, m_rxclk, m_irq;
    logic [7:0] m_txdata = 8'h00;
    int         n = 0;
    int         tx_ok_at = 0;
    int         rx_taken_at = 0;
    bit         rx_need_low;
    logic [15:0] m_off;
    bit         m_acc, m_rd, m_wr;

    int         tx_t[$];
    logic [7:0] tx_d[$];
    int         rx_pulses = 0;

    uart_mapped_io #(
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH),
        .TX_HOLD    (HOLD)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .addr     (addr),
        .din      (din),
        .read_en  (read_en),
        .write_en (write_en),
        .acc_en   (acc_en),
        .dout     (dout),
        .hit      (hit),
        .txdata   (txdata),
        .txclk    (txclk),
        .txready  (txready),
        .rxdata   (rxdata),
        .rxclk    (rxclk),
        .rxready  (rxready),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, want, $time);
        end
    endtask

    function automatic logic [7:0] m_status();
        return {2'b00, m_tx_ovf, m_rx_ovr, rxq.size() == DEPTH, rxq.size() != 0,
                txq.size() == 0, txq.size() == DEPTH};
    endfunction

    function automatic logic [7:0] m_dout();
        logic [15:0] off = addr - BASE;
        if (!read_en || off > 16'd2) return 8'h00;
        if (off == 16'd0) return (rxq.size() != 0) ? rxq[0] : 8'h00;
        if (off == 16'd1) return m_status();
        return {6'b000000, m_tx_ie, m_rx_ie};
    endfunction

    // Reference model: queues plus "earliest next strobe" bookkeeping, stepped once per edge.
    always @(posedge clk) begin
        n++;
        if (reset) begin
            rxq.delete();
            txq.delete();
            {m_rx_ie, m_tx_ie, m_rx_ovr, m_tx_ovf} = '0;
            {m_txclk, m_rxclk, m_irq} = '0;
            m_txdata    = 8'h00;
            tx_ok_at    = n + 1;
            rx_need_low = 1'b0;
        end else begin
            m_irq = (m_rx_ie && rxq.size() != 0) || (m_tx_ie && txq.size() == 0);
            m_off = addr - BASE;
            m_acc = acc_en && (m_off < 16'd3);
            m_rd  = read_en;
            m_wr  = write_en && !read_en;
            m_txclk = 1'b0;
            if (n >= tx_ok_at && txq.size() != 0 && txready) begin
                m_txdata = txq.pop_front();
                m_txclk  = 1'b1;
                tx_ok_at = n + HOLD + 2;
            end
            if (m_acc && m_rd && m_off == 16'd0 && rxq.size() != 0) void'(rxq.pop_front());
            if (m_acc && m_wr && m_off == 16'd2) begin
                m_rx_ie = din[0];
                m_tx_ie = din[1];
                if (din[7]) begin
                    m_rx_ovr = 1'b0;
                    m_tx_ovf = 1'b0;
                end
            end
            if (m_acc && m_wr && m_off == 16'd0) begin
                if (txq.size() < DEPTH) txq.push_back(din);
                else m_tx_ovf = 1'b1;
            end
            m_rxclk = 1'b0;
            if (rx_need_low) begin
                if (n >= rx_taken_at + 2 && !rxready) rx_need_low = 1'b0;
            end else if (rxready) begin
                if (rxq.size() < DEPTH) rxq.push_back(rxdata);
                else m_rx_ovr = 1'b1;
                m_rxclk     = 1'b1;
                rx_need_low = 1'b1;
                rx_taken_at = n;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("hit",    32'(hit),    32'((addr - BASE) < 16'd3));
            chk("dout",   32'(dout),   32'(m_dout()));
            chk("txclk",  32'(txclk),  32'(m_txclk));
            chk("txdata", 32'(txdata), 32'(m_txdata));
            chk("rxclk",  32'(rxclk),  32'(m_rxclk));
            chk("irq",    32'(irq),    32'(m_irq));
        end
        if (txclk === 1'b1) begin
            tx_t.push_back(n);
            tx_d.push_back(txdata);
        end
        if (rxclk === 1'b1) rx_pulses++;
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        addr = a; din = d; write_en = 1'b1; read_en = 1'b0; acc_en = 1'b1;
        cycle();
        acc_en = 1'b0; write_en = 1'b0;
    endtask

    task automatic rd_chk(input string name, input logic [15:0] a, input logic [7:0] want);
        addr = a; read_en = 1'b1; acc_en = 1'b1;
        #1;
        chk(name, 32'(dout), 32'(want));
        cycle();
        acc_en = 1'b0; read_en = 1'b0;
    endtask

    task automatic peek(input string name, input logic [15:0] a, input logic [7:0] want);
        addr = a; read_en = 1'b1;
        #1;
        chk(name, 32'(dout), 32'(want));
        read_en = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] d);
        rxdata = d; rxready = 1'b1;
        cycle();
        rxready = 1'b0;
        repeat (3) cycle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        reset = 1'b1; addr = 16'h0000; din = 8'h00; read_en = 1'b0; write_en = 1'b0;
        acc_en = 1'b0; txready = 1'b0; rxdata = 8'h00; rxready = 1'b0;
        repeat (3) cycle();
        cmp_on = 1'b1;
        reset = 1'b0;
        cycle();

        peek("rst_status", A_STAT, 8'h02);
        peek("rst_data", A_DATA, 8'h00);
        chk("rst_irq", 32'(irq), 32'd0);
        chk("rst_txclk", 32'(txclk), 32'd0);
        chk("rst_rxclk", 32'(rxclk), 32'd0);
        addr = 16'hF003; #1;
        chk("miss_hi_hit", 32'(hit), 32'd0);
        addr = 16'hEFFF; #1;
        chk("miss_lo_hit", 32'(hit), 32'd0);

        txready = 1'b1;
        b = tx_t.size();
        bus_write(A_DATA, 8'h41);
        bus_write(A_DATA, 8'h42);
        for (int i = 0; i < 40 && tx_t.size() < b + 2; i++) cycle();
        chk("tx_pulse_count", 32'(tx_t.size() - b), 32'd2);
        if (tx_t.size() >= b + 2) begin
            chk("tx_first", 32'(tx_d[b]), 32'h41);
            chk("tx_second", 32'(tx_d[b + 1]), 32'h42);
            chk("tx_spacing", 32'(tx_t[b + 1] - tx_t[b]), 32'd5);
        end
        repeat (8) cycle();
        peek("tx_drained", A_STAT, 8'h02);

        txready = 1'b0;
        for (int i = 0; i < 5; i++) bus_write(A_DATA, 8'(8'h10 + i));
        peek("tx_ovf_status", A_STAT, 8'h21);
        bus_write(A_CTRL, 8'h80);
        peek("tx_ovf_cleared", A_STAT, 8'h01);
        peek("ctrl_bit7_reads0", A_CTRL, 8'h00);
        b = tx_t.size();
        txready = 1'b1;
        for (int i = 0; i < 80 && tx_t.size() < b + 4; i++) cycle();
        chk("tx_full_drain_count", 32'(tx_t.size() - b), 32'd4);
        if (tx_t.size() >= b + 4) begin
            chk("tx_full_drain_first", 32'(tx_d[b]), 32'h10);
            chk("tx_full_drain_last", 32'(tx_d[b + 3]), 32'h13);
        end
        repeat (8) cycle();
        peek("tx_empty_again", A_STAT, 8'h02);

        b = rx_pulses;
        rxdata = 8'h5A; rxready = 1'b1;
        repeat (10) cycle();
        rxready = 1'b0;
        repeat (3) cycle();
        chk("rx_held_once", 32'(rx_pulses - b), 32'd1);
        peek("rx_one_status", A_STAT, 8'h06);
        rd_chk("rx_read_5a", A_DATA, 8'h5A);
        rd_chk("rx_read_empty", A_DATA, 8'h00);

        b = rx_pulses;
        for (int i = 0; i < 5; i++) rx_pulse(8'(8'h60 + i));
        chk("rx_ovr_pulses", 32'(rx_pulses - b), 32'd5);
        peek("rx_ovr_status", A_STAT, 8'h1E);
        for (int i = 0; i < 4; i++) rd_chk("rx_ovr_drain", A_DATA, 8'(8'h60 + i));
        peek("rx_ovr_sticky", A_STAT, 8'h12);
        bus_write(A_CTRL, 8'h80);
        peek("rx_ovr_cleared", A_STAT, 8'h02);

        for (int i = 0; i < 4; i++) rx_pulse(8'(8'h81 + i));
        peek("rx_full_status", A_STAT, 8'h0E);
        rxdata = 8'h85; rxready = 1'b1;
        addr = A_DATA; read_en = 1'b1; acc_en = 1'b1;
        #1;
        chk("pop_push_head", 32'(dout), 32'h81);
        cycle();
        rxready = 1'b0; acc_en = 1'b0; read_en = 1'b0;
        repeat (3) cycle();
        peek("pop_push_status", A_STAT, 8'h0E);
        for (int i = 0; i < 4; i++) rd_chk("pop_push_drain", A_DATA, 8'(8'h82 + i));
        peek("pop_push_empty", A_STAT, 8'h02);

        txready = 1'b0;
        addr = A_DATA; din = 8'h99; read_en = 1'b1; write_en = 1'b1; acc_en = 1'b1;
        cycle();
        acc_en = 1'b0; read_en = 1'b0; write_en = 1'b0;
        peek("rw_is_read", A_STAT, 8'h02);
        txready = 1'b1;

        bus_write(A_CTRL, 8'h01);
        rxdata = 8'h77; rxready = 1'b1;
        cycle();
        rxready = 1'b0;
        chk("irq_at_push", 32'(irq), 32'd0);
        cycle();
        chk("irq_after_push", 32'(irq), 32'd1);
        repeat (2) cycle();
        peek("ctrl_rx_ie", A_CTRL, 8'h01);
        rd_chk("irq_rx_data", A_DATA, 8'h77);
        chk("irq_at_pop", 32'(irq), 32'd1);
        cycle();
        chk("irq_after_pop", 32'(irq), 32'd0);
        bus_write(A_CTRL, 8'h02);
        cycle();
        chk("irq_tx_empty", 32'(irq), 32'd1);
        peek("ctrl_tx_ie", A_CTRL, 8'h02);

        bus_write(A_CTRL, 8'h00);
        bus_write(A_DATA, 8'hAB);
        cycle();
        chk("mid_strobe", 32'(txclk), 32'd1);
        chk("mid_txdata", 32'(txdata), 32'hAB);
        reset = 1'b1;
        cycle();
        chk("reset_kills_strobe", 32'(txclk), 32'd0);
        chk("reset_txdata", 32'(txdata), 32'd0);
        reset = 1'b0;
        cycle();
        peek("post_reset_status", A_STAT, 8'h02);
        chk("post_reset_irq", 32'(irq), 32'd0);

        repeat (2) cycle();
        cmp_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
